// File: rtl/regfile_access_arbiter.sv
// Shares the register file's single read and write ports between NUM_REQ round-robin
// readers and one writeback writer; writes win, one read outstanding, read timeout.
module regfile_access_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        rd_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] rd_addr,
  output logic [NUM_REQ-1:0]        rd_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  input  logic                      wr_valid,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      wr_ready,
  output logic                      rf_write_enable,
  output logic [ADDR_W-1:0]         rf_write_address,
  output logic [DATA_W-1:0]         rf_write_data,
  output logic                      rf_read_enable,
  output logic [ADDR_W-1:0]         rf_read_address,
  input  logic [DATA_W-1:0]         rf_read_data,
  input  logic                      rf_read_data_valid,
  output logic                      stray_resp
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_WAIT} state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [TMR_W-1:0]   r_timer;
  logic               r_rf_write_enable;
  logic [ADDR_W-1:0]  r_rf_write_address;
  logic [DATA_W-1:0]  r_rf_write_data;
  logic               r_rf_read_enable;
  logic [ADDR_W-1:0]  r_rf_read_address;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;
  logic               r_rsp_err;
  logic               r_stray_resp;

  logic               w_idle;
  logic               w_rd_go;
  logic [PTR_W-1:0]   w_grant;
  logic [ADDR_W-1:0]  w_grant_addr;
  logic [NUM_REQ-1:0] w_owner_onehot;

  function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // Descending scan so the requester closest to r_rr_ptr is the last to overwrite.
  always_comb begin
    w_grant = r_rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rd_valid[rr_index(r_rr_ptr, k)]) w_grant = rr_index(r_rr_ptr, k);
    end
  end

  assign w_idle       = (r_state == S_IDLE);
  assign wr_ready     = w_idle & wr_valid;
  assign w_rd_go      = w_idle & ~wr_valid & (|rd_valid);
  assign w_grant_addr = rd_addr[int'(w_grant)*ADDR_W +: ADDR_W];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign rd_ready[gi]       = w_rd_go && (w_grant == PTR_W'(gi));
      assign w_owner_onehot[gi] = (r_owner == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= S_IDLE;
      r_rr_ptr           <= '0;
      r_owner            <= '0;
      r_timer            <= '0;
      r_rf_write_enable  <= 1'b0;
      r_rf_write_address <= '0;
      r_rf_write_data    <= '0;
      r_rf_read_enable   <= 1'b0;
      r_rf_read_address  <= '0;
      r_rsp_valid        <= '0;
      r_rsp_data         <= '0;
      r_rsp_err          <= 1'b0;
      r_stray_resp       <= 1'b0;
    end else begin
      r_rf_write_enable <= 1'b0;
      r_rf_read_enable  <= 1'b0;
      r_rsp_valid       <= '0;
      r_rsp_err         <= 1'b0;
      r_stray_resp      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_stray_resp <= rf_read_data_valid;
          if (wr_valid) begin
            r_rf_write_enable  <= 1'b1;
            r_rf_write_address <= wr_addr;
            r_rf_write_data    <= wr_data;
            r_state            <= S_WR;
          end else if (w_rd_go) begin
            r_rf_read_enable  <= 1'b1;
            r_rf_read_address <= w_grant_addr;
            r_owner           <= w_grant;
            r_rr_ptr          <= rr_index(w_grant, 1);
            r_timer           <= '0;
            r_state           <= S_RD;
          end
        end
        S_WR: begin
          r_stray_resp <= rf_read_data_valid;
          r_state      <= S_IDLE;
        end
        S_RD, S_WAIT: begin
          if (rf_read_data_valid) begin
            r_rsp_valid <= w_owner_onehot;
            r_rsp_data  <= rf_read_data;
            r_state     <= S_IDLE;
          end else if (r_state == S_WAIT && r_timer == TMR_W'(TIMEOUT)) begin
            // Cycles T..T+TIMEOUT have all passed without data: report an error.
            r_rsp_valid <= w_owner_onehot;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
            r_state <= S_WAIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rf_write_enable  = r_rf_write_enable;
  assign rf_write_address = r_rf_write_address;
  assign rf_write_data    = r_rf_write_data;
  assign rf_read_enable   = r_rf_read_enable;
  assign rf_read_address  = r_rf_read_address;
  assign rsp_valid        = r_rsp_valid;
  assign rsp_data         = r_rsp_data;
  assign rsp_err          = r_rsp_err;
  assign stray_resp       = r_stray_resp;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: directed scenarios then random traffic, checked
// against a transaction-level model of grants, write/read issue and response timing.
module tb_regfile_access_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NUM_REQ-1:0] rd_valid = '0;
  logic [NUM_REQ*ADDR_W-1:0] rd_addr = '0;
  logic [NUM_REQ-1:0] rd_ready, rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic rsp_err;
  logic wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic wr_ready, rf_write_enable, rf_read_enable, stray_resp;
  logic [ADDR_W-1:0] rf_write_address, rf_read_address;
  logic [DATA_W-1:0] rf_write_data;
  logic [DATA_W-1:0] rf_read_data = '0;
  logic rf_read_data_valid = 1'b0;

  regfile_access_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rf_write_enable(rf_write_enable), .rf_write_address(rf_write_address), .rf_write_data(rf_write_data),
    .rf_read_enable(rf_read_enable), .rf_read_address(rf_read_address),
    .rf_read_data(rf_read_data), .rf_read_data_valid(rf_read_data_valid), .stray_resp(stray_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int idle_from = 0;
  int rd_iss_cyc = -1, wr_cyc = -1, resp_cyc = -1, stray_cyc = -1;
  int resp_own = 0, rr_next = 0, next_lat = 0, rf_lat = 0, rf_cnt = -1;
  logic [ADDR_W-1:0] rd_iss_addr, wr_a, wa_g;
  logic [DATA_W-1:0] wr_d, wd_g, resp_d, rf_hold;
  logic resp_e;
  logic chk_zero = 1'b1;
  logic force_stray = 1'b0;
  logic [ADDR_W-1:0] ra [NUM_REQ];
  logic [DATA_W-1:0] mem [32];
  int grants [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Register file model: stores writes, answers a read rf_lat cycles after issue (-1 = never).
  initial begin
    forever begin
      @(posedge clk); #2;
      rf_read_data_valid = 1'b0;
      if (reset) rf_cnt = -1;
      else begin
        if (rf_write_enable) mem[rf_write_address] = rf_write_data;
        if (rf_read_enable) begin rf_cnt = rf_lat; rf_hold = mem[rf_read_address]; end
        if (rf_cnt == 0) begin rf_read_data_valid = 1'b1; rf_read_data = rf_hold; end
        if (rf_cnt >= 0) rf_cnt--;
        if (force_stray) begin rf_read_data_valid = 1'b1; rf_read_data = 32'hBAD0BAD0; force_stray = 1'b0; end
      end
    end
  end

  task automatic step();
    logic [NUM_REQ-1:0] er;
    @(posedge clk); #1;
    cyc++;
    chk("rf_read_enable", rf_read_enable, cyc == rd_iss_cyc);
    if (cyc == rd_iss_cyc) chk("rf_read_address", rf_read_address, rd_iss_addr);
    chk("rf_write_enable", rf_write_enable, cyc == wr_cyc);
    if (cyc == wr_cyc) begin
      chk("rf_write_address", rf_write_address, wr_a);
      chk("rf_write_data", rf_write_data, wr_d);
    end
    er = (cyc == resp_cyc) ? NUM_REQ'(1 << resp_own) : '0;
    chk("rsp_valid", rsp_valid, er);
    if (cyc == resp_cyc) begin
      chk("rsp_data", rsp_data, resp_d);
      chk("rsp_err", rsp_err, resp_e);
    end
    chk("stray_resp", stray_resp, cyc == stray_cyc);
    if (chk_zero) begin
      chk("zero_rsp_data", rsp_data, 0);
      chk("zero_rsp_err", rsp_err, 0);
      chk("zero_rf_read_address", rf_read_address, 0);
      chk("zero_rf_write_address", rf_write_address, 0);
      chk("zero_rf_write_data", rf_write_data, 0);
      chk_zero = 1'b0;
    end
  endtask

  task automatic drive(input logic [NUM_REQ-1:0] rdv, input logic wrv, input logic rst,
                       output logic [NUM_REQ-1:0] racc, output logic wacc);
    logic [NUM_REQ-1:0] exp_rr;
    logic exp_wr;
    int g;
    reset = rst; rd_valid = rdv; wr_valid = wrv; wr_addr = wa_g; wr_data = wd_g;
    for (int r = 0; r < NUM_REQ; r++) rd_addr[r*ADDR_W +: ADDR_W] = ra[r];
    #1;
    racc = '0; wacc = 1'b0; exp_rr = '0; exp_wr = 1'b0; g = -1;
    if (!rst && cyc >= idle_from) begin
      if (wrv) exp_wr = 1'b1;
      else for (int k = 0; k < NUM_REQ; k++) if (g < 0 && rdv[(rr_next + k) % NUM_REQ]) g = (rr_next + k) % NUM_REQ;
    end
    if (g >= 0) exp_rr[g] = 1'b1;
    chk("wr_ready", wr_ready, exp_wr);
    chk("rd_ready", rd_ready, exp_rr);
    if (exp_wr) begin
      wacc = 1'b1; wr_cyc = cyc + 1; wr_a = wa_g; wr_d = wd_g; idle_from = cyc + 2;
    end
    if (g >= 0) begin
      racc[g] = 1'b1; grants.push_back(g); rr_next = (g + 1) % NUM_REQ;
      rd_iss_cyc = cyc + 1; rd_iss_addr = ra[g]; resp_own = g; rf_lat = next_lat;
      if (next_lat < 0) begin resp_cyc = cyc + TIMEOUT + 2; resp_d = '0; resp_e = 1'b1; end
      else begin resp_cyc = cyc + next_lat + 2; resp_d = mem[ra[g]]; resp_e = 1'b0; end
      idle_from = resp_cyc;
    end
    if (rst) begin
      rd_iss_cyc = -1; wr_cyc = -1; resp_cyc = -1; stray_cyc = -1;
      rr_next = 0; idle_from = cyc + 1; chk_zero = 1'b1;
    end
  endtask

  task automatic run(input logic [NUM_REQ-1:0] rdv, input logic wrv, input int lat, input int budget);
    logic [NUM_REQ-1:0] pend, acc;
    logic wpend, wacc;
    int n;
    pend = rdv; wpend = wrv; n = 0; next_lat = lat;
    while ((pend != 0 || wpend || cyc < idle_from) && n < budget) begin
      step(); drive(pend, wpend, 1'b0, acc, wacc);
      pend &= ~acc; wpend &= ~wacc; n++;
      if (acc != 0) $display("cycle %0d read grant %0d", cyc, grants[$]);
      if (wacc) $display("cycle %0d write accept addr %0h", cyc, wa_g);
    end
    chk("run_within_budget", n < budget, 1);
  endtask

  initial begin
    logic [NUM_REQ-1:0] acc, rp;
    logic wacc, wp;
    int n;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[5] = 32'hDEADBEEF;
    ra[0] = '0; ra[1] = '0; wa_g = '0; wd_g = '0;

    step(); drive('0, 1'b0, 1'b1, acc, wacc);
    step(); drive('0, 1'b0, 1'b0, acc, wacc);

    // Both requesters held: alternating grants starting from requester 0.
    ra[0] = 5'd10; ra[1] = 5'd11; grants.delete(); next_lat = 1; n = 0;
    while (grants.size() < 4 && n < 60) begin
      step(); drive(2'b11, 1'b0, 1'b0, acc, wacc); n++;
      if (acc != 0) $display("cycle %0d read grant %0d", cyc, grants[$]);
    end
    chk("t2_grant_count", grants.size(), 4);
    if (grants.size() == 4) begin
      chk("t2_grant0", grants[0], 0); chk("t2_grant1", grants[1], 1);
      chk("t2_grant2", grants[2], 0); chk("t2_grant3", grants[3], 1);
    end
    run('0, 1'b0, 0, 40);

    // req0 reads address 5, data returned two cycles after issue.
    ra[0] = 5'd5;
    run(2'b01, 1'b0, 2, 40);

    // Write and read of the same address together: write first.
    ra[1] = 5'd3; wa_g = 5'd3; wd_g = 32'h1234;
    run(2'b10, 1'b1, 1, 40);

    // No rf response: timeout error, then a late valid shows as stray.
    ra[0] = 5'd9;
    run(2'b01, 1'b0, -1, 40);
    step(); force_stray = 1'b1; stray_cyc = cyc + 1; drive('0, 1'b0, 1'b0, acc, wacc);
    step(); drive('0, 1'b0, 1'b0, acc, wacc);
    step(); drive('0, 1'b0, 1'b0, acc, wacc);

    // Reset during WAIT abandons the read; round-robin restarts at requester 0.
    ra[0] = 5'd7; next_lat = -1; n = 0; acc = '0;
    while (acc == 0 && n < 20) begin step(); drive(2'b01, 1'b0, 1'b0, acc, wacc); n++; end
    for (int i = 0; i < 5; i++) begin step(); drive('0, 1'b0, 1'b0, acc, wacc); end
    step(); drive('0, 1'b0, 1'b1, acc, wacc);
    $display("cycle %0d reset during wait", cyc);
    grants.delete();
    run(2'b11, 1'b0, 1, 60);
    chk("t5_grant_count", grants.size(), 2);
    if (grants.size() == 2) begin
      chk("t5_first_grant", grants[0], 0); chk("t5_second_grant", grants[1], 1);
    end
    grants.delete();
    ra[1] = 5'd12;
    run(2'b10, 1'b0, 0, 40);
    chk("t5_req1_count", grants.size(), 1);
    if (grants.size() == 1) chk("t5_req1_grant", grants[0], 1);

    // Random traffic.
    rp = '0; wp = 1'b0;
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < NUM_REQ; r++)
        if (!rp[r] && $urandom_range(0, 2) == 0) begin rp[r] = 1'b1; ra[r] = ADDR_W'($urandom); end
      if (!wp && $urandom_range(0, 4) == 0) begin wp = 1'b1; wa_g = ADDR_W'($urandom); wd_g = $urandom; end
      if ($urandom_range(0, 9) == 0) next_lat = -1;
      else if ($urandom_range(0, 3) == 0) next_lat = int'($urandom_range(0, TIMEOUT));
      else next_lat = int'($urandom_range(0, 2));
      step(); drive(rp, wp, 1'b0, acc, wacc);
      if (acc != 0) $display("cycle %0d read grant %0d lat %0d", cyc, grants[$], next_lat);
      if (wacc) $display("cycle %0d write accept addr %0h", cyc, wa_g);
      rp &= ~acc; wp &= ~wacc;
    end
    run('0, 1'b0, 0, 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
